// File: rtl/pong_if.sv
// Pong engine I/O bundle.
//   master: drives the frame strobe, match control and paddle buttons.
//   slave : the engine; returns object positions, scores, match state and
//           the point pulse to the renderer.
interface pong_if #(
  parameter int POS_W = 10
);
  logic             frame_tick;
  logic             start;
  logic             mode_2p;
  logic             l_up, l_dn;
  logic             r_up, r_dn;
  logic [POS_W-1:0] ball_x, ball_y;
  logic [POS_W-1:0] pad_l_y, pad_r_y;
  logic [3:0]       score_l, score_r;
  logic [1:0]       state;
  logic             point;

  modport master (
    output frame_tick, start, mode_2p, l_up, l_dn, r_up, r_dn,
    input  ball_x, ball_y, pad_l_y, pad_r_y, score_l, score_r, state, point
  );

  modport slave (
    input  frame_tick, start, mode_2p, l_up, l_dn, r_up, r_dn,
    output ball_x, ball_y, pad_l_y, pad_r_y, score_l, score_r, state, point
  );
endinterface

// File: rtl/pong_engine.sv
// Pong game core: ball physics, paddle control, scoring and match FSM.
// One game step fires every FRAME_DIV frame strobes; all game state moves
// only on step cycles and every output is a register.
// Ports:
//   clk, rst_n : pixel clock, asynchronous active-low reset
//   bus        : pong_if slave (inputs frame_tick/start/mode_2p/buttons,
//                outputs ball/paddle positions, scores, state, point)
module pong_engine #(
  parameter int POS_W       = 10,
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int BALL_SIZE   = 8,
  parameter int PAD_W       = 8,
  parameter int PAD_H       = 64,
  parameter int PAD_L_X     = 24,
  parameter int PAD_R_X     = 608,
  parameter int BALL_SPEED  = 2,
  parameter int PAD_SPEED   = 4,
  parameter int FRAME_DIV   = 1,
  parameter int SERVE_STEPS = 60,
  parameter int WIN_SCORE   = 9
) (
  input  logic clk,
  input  logic rst_n,
  pong_if.slave bus
);
  // one extra bit so sums like y+size+speed never wrap
  localparam int XW    = POS_W + 1;
  localparam int SC_W  = (SERVE_STEPS > 1) ? $clog2(SERVE_STEPS) : 1;
  localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  localparam logic [XW-1:0] BALL_X0  = XW'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [XW-1:0] BALL_Y0  = XW'((SCREEN_H - BALL_SIZE) / 2);
  localparam logic [XW-1:0] PAD_Y0   = XW'((SCREEN_H - PAD_H) / 2);
  localparam logic [XW-1:0] PAD_MAX  = XW'(SCREEN_H - PAD_H);
  localparam logic [XW-1:0] BALL_YM  = XW'(SCREEN_H - BALL_SIZE);
  localparam logic [XW-1:0] L_FACE   = XW'(PAD_L_X + PAD_W);
  localparam logic [XW-1:0] R_STOP   = XW'(PAD_R_X - BALL_SIZE);
  localparam logic [XW-1:0] BS_E     = XW'(BALL_SIZE);
  localparam logic [XW-1:0] SP_E     = XW'(BALL_SPEED);
  localparam logic [XW-1:0] PS_E     = XW'(PAD_SPEED);
  localparam logic [XW-1:0] PH_E     = XW'(PAD_H);
  localparam logic [XW-1:0] SW_E     = XW'(SCREEN_W);
  localparam logic [XW-1:0] SH_E     = XW'(SCREEN_H);
  localparam logic [XW-1:0] RX_E     = XW'(PAD_R_X);
  localparam logic [3:0]       WIN      = 4'(WIN_SCORE);
  localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(SERVE_STEPS - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SERVE = 2'd1, PLAY = 2'd2, OVER = 2'd3} state_t;

  state_t           state_q;
  logic [POS_W-1:0] ball_x_q, ball_y_q, pad_l_q, pad_r_q;
  logic [3:0]       score_l_q, score_r_q;
  logic             dir_x_q;  // 1: right
  logic             dir_y_q;  // 1: down
  logic [SC_W-1:0]  serve_cnt;
  logic [DIV_W-1:0] div_cnt;
  logic             point_q;

  function automatic logic [XW-1:0] pad_next(input logic [XW-1:0] y,
                                             input logic up, input logic dn);
    logic [XW-1:0] r;
    r = y;
    if (up && !dn)      r = (y < PS_E) ? '0 : y - PS_E;
    else if (dn && !up) r = (y + PS_E > PAD_MAX) ? PAD_MAX : y + PS_E;
    return r;
  endfunction

  logic [XW-1:0] bx, by, pl, pr, ball_c, pad_c, pl_nxt, pr_nxt, nx, ny;
  logic          cpu_up, cpu_dn, l_up_e, l_dn_e, ndy;
  logic          ovl_l, ovl_r, hit_l, hit_r, miss_l, miss_r, step;
  logic [3:0]    sl_inc, sr_inc;

  assign bx = {1'b0, ball_x_q};
  assign by = {1'b0, ball_y_q};
  assign pl = {1'b0, pad_l_q};
  assign pr = {1'b0, pad_r_q};

  assign step = bus.frame_tick && (div_cnt == DIV_LAST);

  // CPU paddle chases the ball centre with a PAD_SPEED dead band
  assign ball_c = by + XW'(BALL_SIZE / 2);
  assign pad_c  = pl + XW'(PAD_H / 2);
  assign cpu_dn = ball_c > pad_c + PS_E;
  assign cpu_up = pad_c > ball_c + PS_E;
  assign l_up_e = bus.mode_2p ? bus.l_up : cpu_up;
  assign l_dn_e = bus.mode_2p ? bus.l_dn : cpu_dn;
  assign pl_nxt = pad_next(pl, l_up_e, l_dn_e);
  assign pr_nxt = pad_next(pr, bus.r_up, bus.r_dn);

  always_comb begin
    ny  = by;
    ndy = dir_y_q;
    if (!dir_y_q) begin
      if (by < SP_E) begin ny = '0; ndy = 1'b1; end
      else ny = by - SP_E;
    end else if (by + BS_E + SP_E > SH_E) begin
      ny = BALL_YM; ndy = 1'b0;
    end else ny = by + SP_E;
  end

  // collisions use pre-step paddle positions; the face test fires only on
  // the step that would carry the ball across the paddle face
  assign ovl_l  = (by + BS_E > pl) && (by < pl + PH_E);
  assign ovl_r  = (by + BS_E > pr) && (by < pr + PH_E);
  assign hit_l  = !dir_x_q && (bx >= L_FACE) && (bx < L_FACE + SP_E) && ovl_l;
  assign hit_r  = dir_x_q && (bx + BS_E <= RX_E) && (bx + BS_E + SP_E > RX_E) && ovl_r;
  assign miss_l = !dir_x_q && !hit_l && (bx < SP_E);
  assign miss_r = dir_x_q && !hit_r && (bx + BS_E + SP_E > SW_E);

  // bx-SP_E wraps only when miss_l is set, in which case nx is unused
  assign nx = hit_l ? L_FACE : hit_r ? R_STOP : dir_x_q ? bx + SP_E : bx - SP_E;

  assign sl_inc = (score_l_q < WIN) ? score_l_q + 4'd1 : score_l_q;
  assign sr_inc = (score_r_q < WIN) ? score_r_q + 4'd1 : score_r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ball_x_q  <= BALL_X0[POS_W-1:0];
      ball_y_q  <= BALL_Y0[POS_W-1:0];
      pad_l_q   <= PAD_Y0[POS_W-1:0];
      pad_r_q   <= PAD_Y0[POS_W-1:0];
      score_l_q <= '0;
      score_r_q <= '0;
      dir_x_q   <= 1'b1;
      dir_y_q   <= 1'b1;
      serve_cnt <= '0;
      div_cnt   <= '0;
      point_q   <= 1'b0;
    end else begin
      point_q <= 1'b0;
      if (bus.frame_tick) div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
      if (step) begin
        case (state_q)
          IDLE, OVER: if (bus.start) begin
            state_q   <= SERVE;
            score_l_q <= '0;
            score_r_q <= '0;
            serve_cnt <= '0;
            ball_x_q  <= BALL_X0[POS_W-1:0];
            ball_y_q  <= BALL_Y0[POS_W-1:0];
          end
          SERVE: begin
            pad_l_q  <= pl_nxt[POS_W-1:0];
            pad_r_q  <= pr_nxt[POS_W-1:0];
            ball_x_q <= BALL_X0[POS_W-1:0];
            ball_y_q <= BALL_Y0[POS_W-1:0];
            if (serve_cnt == SC_LAST) begin
              state_q   <= PLAY;
              serve_cnt <= '0;
            end else serve_cnt <= serve_cnt + 1'b1;
          end
          PLAY: begin
            pad_l_q <= pl_nxt[POS_W-1:0];
            pad_r_q <= pr_nxt[POS_W-1:0];
            dir_y_q <= ndy;
            if (miss_l || miss_r) begin
              // recentre and serve toward whoever conceded
              ball_x_q  <= BALL_X0[POS_W-1:0];
              ball_y_q  <= BALL_Y0[POS_W-1:0];
              point_q   <= 1'b1;
              serve_cnt <= '0;
              if (miss_l) begin
                score_r_q <= sr_inc;
                dir_x_q   <= 1'b0;
                state_q   <= (sr_inc == WIN) ? OVER : SERVE;
              end else begin
                score_l_q <= sl_inc;
                dir_x_q   <= 1'b1;
                state_q   <= (sl_inc == WIN) ? OVER : SERVE;
              end
            end else begin
              ball_x_q <= nx[POS_W-1:0];
              ball_y_q <= ny[POS_W-1:0];
              if (hit_l) dir_x_q <= 1'b1;
              if (hit_r) dir_x_q <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.ball_x  = ball_x_q;
  assign bus.ball_y  = ball_y_q;
  assign bus.pad_l_y = pad_l_q;
  assign bus.pad_r_y = pad_r_q;
  assign bus.score_l = score_l_q;
  assign bus.score_r = score_r_q;
  assign bus.state   = state_q;
  assign bus.point   = point_q;
endmodule
